// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// wait-state count between request acceptance and response.
// Stores commit on the acceptance edge; loads sample storage when the
// response is formed, so a load always observes every earlier store.
// Optional build macro DMEM_RSP_ERR_EN enables access-fault detection
// (out-of-range word index, misaligned halfword/word loads).
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  input  logic [2:0]  req_load_ctrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;

  logic [31:0] mem [DEPTH_WORDS];

  // Request fields captured at acceptance
  logic        wr_q;
  logic [31:0] addr_q;
  logic [3:0]  mask_q;
  logic [2:0]  ctrl_q;

  // Current access view: live request while IDLE, captured request afterwards
  logic        cur_wr;
  logic [31:0] cur_addr;
  logic [2:0]  cur_ctrl;
  logic [AW-1:0] cur_idx;
  logic        cur_fault;

  logic        accept;
  logic        enter_rsp;

  // Byte/halfword extraction with sign or zero extension by funct3
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b010:  load_extract = w;
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = 32'd0;
    endcase
  endfunction

`ifdef DMEM_RSP_ERR_EN
  // Range check applies to all accesses; stores arrive lane-aligned via the
  // mask, so only loads are checked for natural alignment.
  function automatic logic access_fault(input logic [31:0] a,
                                        input logic        wr,
                                        input logic [2:0]  f3);
    logic range_bad;
    logic align_bad;
    range_bad = ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    align_bad = 1'b0;
    if (!wr) begin
      if ((f3 == 3'b001 || f3 == 3'b101) && a[0])
        align_bad = 1'b1;
      if (f3 == 3'b010 && a[1:0] != 2'b00)
        align_bad = 1'b1;
    end
    access_fault = range_bad | align_bad;
  endfunction

  assign cur_fault = access_fault(cur_addr, cur_wr, cur_ctrl);
  logic unused_bits;
  assign unused_bits = &{1'b0, mask_q};
`else
  assign cur_fault = 1'b0;
  logic unused_bits;
  assign unused_bits = &{1'b0, mask_q, cur_addr[31:AW+2]};
`endif

  assign cur_wr   = (state == IDLE) ? req_wr        : wr_q;
  assign cur_addr = (state == IDLE) ? req_addr      : addr_q;
  assign cur_ctrl = (state == IDLE) ? req_load_ctrl : ctrl_q;
  assign cur_idx  = cur_addr[AW+1:2];

  assign accept    = req_valid && req_ready && !rst;
  assign enter_rsp = !rst &&
                     (((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd1)));

  // State register and wait-state counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 4'(WAIT_CYCLES);
      else if (state == WAIT)
        cnt <= cnt - 4'd1;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state alone
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  // Capture request fields at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q   <= req_wr;
      addr_q <= req_addr;
      mask_q <= req_mask;
      ctrl_q <= req_load_ctrl;
    end
  end

  // Store commit on the acceptance edge, lane by lane; storage is never reset
  always_ff @(posedge clk) begin
    if (accept && req_wr && !cur_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (req_mask[i])
          mem[cur_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Response data and fault flag formed on entry to RESP, held until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_rsp) begin
      rsp_err <= cur_fault;
      if (cur_fault || cur_wr)
        rsp_rdata <= 32'd0;
      else
        rsp_rdata <= load_extract(mem[cur_idx], cur_addr[1:0], cur_ctrl);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic [2:0]  req_load_ctrl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors = 0;
  int errors  = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .req_load_ctrl(req_load_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: present, accept, measure latency, check, take.
  task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [2:0] ctrl, input logic [31:0] exp_rdata,
                      input logic exp_err);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    req_mask = mask; req_load_ctrl = ctrl;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WAITC + 1));
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_mask = 4'd0; req_load_ctrl = 3'd0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_ready", 32'(req_ready), 32'd1);

    // Word store / load and extension
    xact("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 3'b010, 32'h0, 1'b0);
    xact("lw10", 1'b0, 32'h10, 32'h0, 4'b0000, 3'b010, 32'hDEADBEEF, 1'b0);
    xact("lb13", 1'b0, 32'h13, 32'h0, 4'b0000, 3'b000, 32'hFFFFFFDE, 1'b0);
    xact("lbu13", 1'b0, 32'h13, 32'h0, 4'b0000, 3'b100, 32'h000000DE, 1'b0);
    xact("lh10", 1'b0, 32'h10, 32'h0, 4'b0000, 3'b001, 32'hFFFFBEEF, 1'b0);
    xact("lhu12", 1'b0, 32'h12, 32'h0, 4'b0000, 3'b101, 32'h0000DEAD, 1'b0);
    xact("lbu11", 1'b0, 32'h11, 32'h0, 4'b0000, 3'b100, 32'h000000BE, 1'b0);
    xact("lb11", 1'b0, 32'h11, 32'h0, 4'b0000, 3'b000, 32'hFFFFFFBE, 1'b0);
    xact("f3_011", 1'b0, 32'h10, 32'h0, 4'b0000, 3'b011, 32'h0, 1'b0);
    xact("f3_111", 1'b0, 32'h10, 32'h0, 4'b0000, 3'b111, 32'h0, 1'b0);

    // Byte-lane store and empty-mask store
    xact("sb_lane2", 1'b1, 32'h10, 32'h00AA0000, 4'b0100, 3'b000, 32'h0, 1'b0);
    xact("lw_lane2", 1'b0, 32'h10, 32'h0, 4'b0000, 3'b010, 32'hDEAABEEF, 1'b0);
    xact("s_mask0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 3'b010, 32'h0, 1'b0);
    xact("lw_mask0", 1'b0, 32'h10, 32'h0, 4'b0000, 3'b010, 32'hDEAABEEF, 1'b0);

    // Backpressure: response held while rsp_ready is low
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_load_ctrl = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_wait_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_rdata", rsp_rdata, 32'hDEAABEEF);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_after_valid", 32'(rsp_valid), 32'd0);
    check("bp_after_ready", 32'(req_ready), 32'd1);

    // Reset during WAIT after a store: no response, store retained
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
    req_mask = 4'b1111; req_load_ctrl = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rw_in_wait", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rw_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rw_no_rsp", 32'(rsp_valid), 32'd0);
      check("rw_ready", 32'(req_ready), 32'd1);
    end
    xact("lw20", 1'b0, 32'h20, 32'h0, 4'b0000, 3'b010, 32'h00000055, 1'b0);

    // Reset wins over a simultaneous store request
    xact("sw24", 1'b1, 32'h24, 32'h11, 4'b1111, 3'b010, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h24;
    req_wdata = 32'h77; req_mask = 4'b1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rp_no_rsp", 32'(rsp_valid), 32'd0);
    end
    xact("lw24", 1'b0, 32'h24, 32'h0, 4'b0000, 3'b010, 32'h00000011, 1'b0);

    // Fault handling / address wrapping
    xact("sw00", 1'b1, 32'h0, 32'hA5A5A5A5, 4'b1111, 3'b010, 32'h0, 1'b0);
`ifdef DMEM_RSP_ERR_EN
    xact("lw12_fault", 1'b0, 32'h12, 32'h0, 4'b0000, 3'b010, 32'h0, 1'b1);
    xact("lh11_fault", 1'b0, 32'h11, 32'h0, 4'b0000, 3'b001, 32'h0, 1'b1);
    xact("sw_oor", 1'b1, 32'(4 * DEPTH), 32'h12345678, 4'b1111, 3'b010, 32'h0, 1'b1);
    xact("lw00_kept", 1'b0, 32'h0, 32'h0, 4'b0000, 3'b010, 32'hA5A5A5A5, 1'b0);
    xact("lw10_kept", 1'b0, 32'h10, 32'h0, 4'b0000, 3'b010, 32'hDEAABEEF, 1'b0);
`else
    xact("lw12_wrap", 1'b0, 32'h12, 32'h0, 4'b0000, 3'b010, 32'hDEAABEEF, 1'b0);
    xact("lh11_wrap", 1'b0, 32'h11, 32'h0, 4'b0000, 3'b001, 32'hFFFFBEEF, 1'b0);
    xact("sw_oor", 1'b1, 32'(4 * DEPTH), 32'h12345678, 4'b1111, 3'b010, 32'h0, 1'b0);
    xact("lw00_wrap", 1'b0, 32'h0, 32'h0, 4'b0000, 3'b010, 32'h12345678, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait-states between request acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts the request this cycle.
REQ-007 SHALL have port req_wr  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, already lane-aligned.
REQ-010 SHALL have port req_mask  input  4  store byte-lane enables.
REQ-011 SHALL have port req_load_ctrl  input  3  load size/sign in RISC-V funct3 encoding.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  initiator takes the response.
REQ-014 SHALL have port rsp_rdata  output  32  load result, extended; 0 for stores.
REQ-015 SHALL have port rsp_err  output  1  access fault flag.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE, decoded from state alone.
REQ-018 SHALL accept a request when req_valid && req_ready, and latch wr, addr, mask, load_ctrl.
REQ-019 SHALL commit a store on the acceptance edge: lane i of word addr[31:2] mod DEPTH_WORDS is written when mask[i]=1; mask 4'b0000 changes no storage but still responds.
REQ-020 SHALL on acceptance go IDLE->WAIT with counter=WAIT_CYCLES, or IDLE->RESP when WAIT_CYCLES=0.
REQ-021 SHALL decrement the counter each WAIT cycle and go WAIT->RESP on the cycle it is 1.
REQ-022 SHALL raise rsp_valid exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-023 SHALL sample load data on entry to RESP; a load follows all earlier accepted stores.
REQ-024 SHALL extract the load result by funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-025 SHALL use addr[1:0] as the byte offset and addr[1] as the half offset, sign- or zero-extended to 32 bits.
REQ-026 SHALL return rsp_rdata=0 for unused funct3 codes (011, 110, 111).
REQ-027 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1.
REQ-028 SHALL go RESP->IDLE on the rsp_valid && rsp_ready edge.
REQ-029 SHALL accept no new request in the same cycle as the response handshake; the next acceptance is the following cycle earliest.
REQ-030 SHALL have at most one request outstanding; req_valid in WAIT/RESP is ignored and not lost by the initiator's contract.

Reset
REQ-031 SHALL on rst=1 at posedge force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-032 SHALL make req_ready=1 in the cycle after reset is released.
REQ-033 SHALL on reset mid-operation abandon the outstanding request with no response; a store already committed stays in memory.
REQ-034 SHALL not reset storage contents.
REQ-035 SHALL make rst take priority over a simultaneous request or response handshake.

Configuration
REQ-036 SHALL support macro DMEM_RSP_ERR_EN.
REQ-037 SHALL with DMEM_RSP_ERR_EN defined flag an access as a fault when addr[31:2] >= DEPTH_WORDS, a halfword has addr[0]=1, or a word has addr[1:0]!=0.
REQ-038 SHALL with DMEM_RSP_ERR_EN defined report a fault with rsp_err=1 and rsp_rdata=0, and suppress the faulting store.
REQ-039 SHALL without DMEM_RSP_ERR_EN tie rsp_err to 0, wrap the address modulo DEPTH_WORDS, and ignore misalignment bits below the access size.

Verification
REQ-040 SHALL cover store/load: SW 0xDEADBEEF to 0x10 mask 1111, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after each acceptance (WAIT_CYCLES=2).
REQ-041 SHALL cover extension on word 0xDEADBEEF at 0x10: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-042 SHALL cover byte store: mask 0100, wdata 0x00AA0000 to 0x10, then LW -> 0xDEAABEEF; a mask 0000 store -> ack, word unchanged.
REQ-043 SHALL cover backpressure: rsp_ready low 5 cycles -> rsp_valid/rsp_rdata held; req_ready=0 throughout; req_ready=1 one cycle after handshake.
REQ-044 SHALL cover reset mid-WAIT after SW 0x55 to 0x20 -> no rsp_valid, req_ready=1 after reset, LW 0x20 -> 0x00000055.
REQ-045 SHALL cover faults with DMEM_RSP_ERR_EN: LW 0x12 -> rsp_err=1, rdata 0; SW to 4*DEPTH_WORDS -> rsp_err=1, storage unchanged; without macro LW 0x12 -> word at 0x10, rsp_err=0.
